// File: rtl/sprite_sorter.sv
// Loads up to 8 sprites from a registered-read buffer, sorts them far-to-near by odd-even transposition.
// Optional SPRITE_CULL_EN: entries with distance <= 0 are stored invalid.
module sprite_sorter #(
    parameter int MAX_SPRITES = 8,
    parameter int QMN_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       num_sprites,
    output logic [2:0]       buf_index,
    output logic             buf_oe,
    output logic             buf_we,
    input  logic [QMN_W-1:0] sdist_in,
    input  logic [10:0]      scol_in,
    output logic             busy,
    output logic             done,
    output logic             results_valid,
    output logic [3:0]       valid_count,
    input  logic [2:0]       rd_slot,
    output logic [2:0]       rd_id,
    output logic [QMN_W-1:0] rd_dist,
    output logic [10:0]      rd_col,
    output logic             rd_valid
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [3:0]               n_q, n_d;
    logic [2:0]               buf_index_q, buf_index_d;
    logic                     buf_oe_q, buf_oe_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rv_q, rv_d;
    logic [3:0]               vc_q, vc_d;
    logic [2:0]               id_q   [MAX_SPRITES];
    logic [2:0]               id_d   [MAX_SPRITES];
    logic signed [QMN_W-1:0]  dist_q [MAX_SPRITES];
    logic signed [QMN_W-1:0]  dist_d [MAX_SPRITES];
    logic [10:0]              col_q  [MAX_SPRITES];
    logic [10:0]              col_d  [MAX_SPRITES];
    logic [MAX_SPRITES-1:0]   vld_q, vld_d;

    logic                     keep_v;
    logic [3:0]               slot_v, next_v, pc_v;
    logic [2:0]               li, ri;
    int unsigned              l;

`ifdef SPRITE_CULL_EN
    assign keep_v = $signed(sdist_in) > 0;
`else
    assign keep_v = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        buf_index_d = buf_index_q;
        buf_oe_d    = buf_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rv_d        = rv_q;
        vc_d        = vc_q;
        id_d        = id_q;
        dist_d      = dist_q;
        col_d       = col_q;
        vld_d       = vld_q;
        slot_v      = cnt_q - 4'd1;
        next_v      = cnt_q + 4'd1;
        pc_v        = '0;
        li          = '0;
        ri          = '0;
        l           = 0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d         = (num_sprites > 4'(MAX_SPRITES)) ? 4'(MAX_SPRITES) : num_sprites;
                    state_d     = S_LOAD;
                    cnt_d       = '0;
                    vld_d       = '0;
                    rv_d        = 1'b0;
                    busy_d      = 1'b1;
                    buf_oe_d    = (n_d != 4'd0);
                    buf_index_d = '0;
                end
            end
            S_LOAD: begin
                // Read data trails the address by one cycle, so cycle k fills slot k-1.
                if (cnt_q != 4'd0) begin
                    id_d[slot_v[2:0]]   = slot_v[2:0];
                    dist_d[slot_v[2:0]] = $signed(sdist_in);
                    col_d[slot_v[2:0]]  = scol_in;
                    vld_d[slot_v[2:0]]  = keep_v;
                end
                if (cnt_q == n_q) begin
                    state_d     = S_SORT;
                    cnt_d       = '0;
                    buf_oe_d    = 1'b0;
                    buf_index_d = '0;
                end else begin
                    cnt_d       = next_v;
                    buf_oe_d    = (next_v < n_q);
                    buf_index_d = buf_oe_d ? next_v[2:0] : 3'd0;
                end
            end
            S_SORT: begin
                for (int unsigned p = 0; p < MAX_SPRITES / 2; p++) begin
                    l  = 2 * p + {31'b0, cnt_q[0]};
                    li = l[2:0];
                    ri = li + 3'd1;
                    if (l + 1 < MAX_SPRITES && vld_q[ri] &&
                        (!vld_q[li] || dist_q[ri] > dist_q[li])) begin
                        id_d[li]   = id_q[ri];
                        id_d[ri]   = id_q[li];
                        dist_d[li] = dist_q[ri];
                        dist_d[ri] = dist_q[li];
                        col_d[li]  = col_q[ri];
                        col_d[ri]  = col_q[li];
                        vld_d[li]  = vld_q[ri];
                        vld_d[ri]  = vld_q[li];
                    end
                end
                if (cnt_q == 4'(MAX_SPRITES - 1)) begin
                    for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
                        pc_v = pc_v + {3'b0, vld_q[i]};
                    end
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rv_d    = 1'b1;
                    vc_d    = pc_v;
                    cnt_d   = '0;
                end else begin
                    cnt_d = next_v;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            buf_index_q <= '0;
            buf_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rv_q        <= 1'b0;
            vc_q        <= '0;
            vld_q       <= '0;
            for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
                id_q[i]   <= '0;
                dist_q[i] <= '0;
                col_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            buf_index_q <= buf_index_d;
            buf_oe_q    <= buf_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rv_q        <= rv_d;
            vc_q        <= vc_d;
            vld_q       <= vld_d;
            id_q        <= id_d;
            dist_q      <= dist_d;
            col_q       <= col_d;
        end
    end

    assign buf_index     = buf_index_q;
    assign buf_oe        = buf_oe_q;
    assign buf_we        = 1'b0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign results_valid = rv_q;
    assign valid_count   = vc_q;
    assign rd_id         = id_q[rd_slot];
    assign rd_dist       = dist_q[rd_slot];
    assign rd_col        = col_q[rd_slot];
    assign rd_valid      = vld_q[rd_slot];
endmodule
